// File: rtl/codificador_sequencial_parametrizado_if.sv
// Request/result bundle for the sequential encoder.
// Master drives requests and ready; slave returns the held code.
interface codificador_sequencial_parametrizado_if #(
  parameter int N = 7
);
  localparam int CW = $clog2(N + 1);

  logic [N-1:0]  din;
  logic          mode;
  logic          code_ready;
  logic [CW-1:0] code_out;
  logic          code_valid;
  logic          err;
  logic          busy;

  modport master (
    output din, mode, code_ready,
    input  code_out, code_valid, err, busy
  );

  modport slave (
    input  din, mode, code_ready,
    output code_out, code_valid, err, busy
  );
endinterface

// File: rtl/codificador_sequencial_parametrizado.sv
// Stability-filtered N-line encoder, strict one-hot or priority.
// One code per press, held on valid/ready until consumed.
module codificador_sequencial_parametrizado #(
  parameter int N             = 7,
  parameter int STABLE_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  codificador_sequencial_parametrizado_if.slave bus
);
  localparam int CW   = $clog2(N + 1);
  localparam int CNTW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNTW:0] LP_SC = (CNTW + 1)'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STABLE,
    S_HOLD,
    S_RELEASE
  } state_t;

  state_t        r_state;
  logic [N-1:0]  r_sample;
  logic [CNTW-1:0] r_cnt;
  logic [CW-1:0] r_code;
  logic          r_valid;
  logic          r_err;

  logic [CNTW:0] w_cnt_inc;
  logic [CW:0]   w_enc_din;
  logic [CW:0]   w_enc_smp;
  logic          w_din_zero;

  // {err, code}: highest set line wins unless strict mode sees >1 line
  function automatic logic [CW:0] f_encode(
    input logic [N-1:0] v,
    input logic         m
  );
    logic [CW-1:0] hi;
    logic          multi;
    hi = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) hi = CW'(i + 1);
    end
    multi = |(v & (v - N'(1)));
    if (!m && multi) return {1'b1, {CW{1'b0}}};
    return {1'b0, hi};
  endfunction

  assign w_cnt_inc  = {1'b0, r_cnt} + (CNTW + 1)'(1);
  assign w_din_zero = (bus.din == '0);
  assign w_enc_din  = f_encode(bus.din, bus.mode);
  assign w_enc_smp  = f_encode(r_sample, bus.mode);

  // Press filter, encode, hold-until-ready and release wait
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sample <= '0;
      r_cnt    <= '0;
      r_code   <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_din_zero) begin
            r_sample <= bus.din;
            r_cnt    <= (CNTW)'(1);
            if (STABLE_CYCLES == 1) begin
              r_code  <= w_enc_din[CW-1:0];
              r_err   <= w_enc_din[CW];
              r_valid <= 1'b1;
              r_state <= S_HOLD;
            end else begin
              r_state <= S_STABLE;
            end
          end
        end
        S_STABLE: begin
          if (w_din_zero) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (bus.din != r_sample) begin
            r_sample <= bus.din;
            r_cnt    <= (CNTW)'(1);
          end else begin
            r_cnt <= w_cnt_inc[CNTW-1:0];
            if (w_cnt_inc == LP_SC) begin
              r_code  <= w_enc_smp[CW-1:0];
              r_err   <= w_enc_smp[CW];
              r_valid <= 1'b1;
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (bus.code_ready) begin
            r_valid <= 1'b0;
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (w_din_zero) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.code_out   = r_code;
  assign bus.code_valid = r_valid;
  assign bus.err        = r_err;
  assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: doc/codificador_sequencial_parametrizado.md
# codificador_sequencial_parametrizado

Registered, parametrised successor to the 7-line one-hot encoder. It filters N request lines for stability and encodes them in strict one-hot mode or in priority mode, flagging invalid input patterns. The result is held on a valid/ready handshake until the consumer takes it. Each press produces exactly one code, and the next code is accepted only after all lines have been released. The block sits between the debounced key/selection inputs and the downstream control logic.

## Interface
- N, default 7: number of input lines; legal range 2..255.
- STABLE_CYCLES, default 4: number of consecutive identical non-zero samples required before encoding; legal range 1..255.
- CW (localparam) = $clog2(N+1): code width; 3 when N=7.

- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- din, input, N: request lines; bit i maps to code i+1.
- mode, input, 1: 0 = strict one-hot, 1 = priority (highest index wins).
- code_ready, input, 1: consumer accepts the result.
- code_out, output, CW: encoded result; 0 means no valid line.
- code_valid, output, 1: code_out and err hold a result.
- err, output, 1: the result came from an illegal pattern in strict mode.
- busy, output, 1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, STABLE, HOLD, RELEASE. The block uses a sample register (N bits) and a counter of $clog2(STABLE_CYCLES+1) bits.
- **IDLE**
  - din==0: remain in IDLE.
  - din!=0: sample<=din and cnt<=1. If STABLE_CYCLES==1, encode immediately and go to HOLD; otherwise go to STABLE.
- **STABLE**
  - din==0: go to IDLE and set cnt<=0.
  - din!=0 and din!=sample: sample<=din, cnt<=1, stay in STABLE. The stability count restarts.
  - din==sample: cnt<=cnt+1. When cnt+1==STABLE_CYCLES, encode and go to HOLD.
- **Encode** (single edge; registers code_out, err, and code_valid<=1; mode is sampled at this edge):
  - mode=0, exactly one bit i set: code_out=i+1, err=0.
  - mode=0, two or more bits set: code_out=0, err=1.
  - mode=1: code_out = (highest set index)+1, err=0.
- **HOLD**
  - code_valid=1; code_out and err are frozen; din and mode are ignored.
  - code_ready=1: code_valid<=0 and go to RELEASE.
- **RELEASE:** wait for din==0 to be sampled on an edge, then go to IDLE. A held line therefore never re-encodes.
- code_out and err keep their last value after the handshake and are only overwritten by the next encode.
- **Reset:** state=IDLE, sample=0, cnt=0, code_out=0, code_valid=0, err=0, busy=0. Reset overrides every other condition, including reset asserted in the middle of STABLE or HOLD. Any pending result is discarded.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: code_valid rises after the STABLE_CYCLES-th consecutive rising edge at which the same non-zero din is sampled. With STABLE_CYCLES=4 that is the 4th edge; with STABLE_CYCLES=1 it is the 1st edge.
- **Handshake:** the transfer occurs on an edge where code_valid=1 and code_ready=1.
  - code_valid drops on that same edge.
  - code_ready while code_valid=0 has no effect.
  - code_ready held permanently high gives a one-cycle code_valid pulse.
- **Minimum cycle per code:** STABLE_CYCLES edges, plus 1 edge for the handshake, plus 1 edge sampling din==0, before IDLE accepts the next press.
- **Simultaneous events:**
  - A din change on the encode edge is ignored, because the encode uses the sample register.
  - din returning to 0 on the handshake edge is not seen until the first RELEASE edge, so it costs one extra edge.
- **Counter:** the counter saturates by construction, since the state leaves STABLE at STABLE_CYCLES. There is no wrap-around.

## Test plan
- **Reset values:** rst=1 for 2 cycles with din=7'h7F → code_out=0, code_valid=0, err=0, busy=0.
- **Strict single line:** N=7, STABLE_CYCLES=4, mode=0, din=7'b0000100 held, code_ready=0 → code_valid rises after the 4th edge with code_out=3, err=0. Set code_ready=1 for one cycle → code_valid=0. With din still held, no re-encode. Set din=0 → state returns to IDLE one edge later.
- **Bounce restart:** din sequence 0x01, 0x01, 0x02, 0x02, 0x02, 0x02 → code_out=2 with valid after the 6th edge. Also din 0x01, 0x01, 0x00 → back to IDLE with no valid.
- **Strict multi-hot:** mode=0, din=7'b1000001 stable → code_out=0, err=1, code_valid=1. Repeat with mode=1 → code_out=7, err=0.
- **Backpressure and reset:** hold code_ready=0 for 20 cycles in HOLD while toggling din → code_out unchanged and valid stays high. Assert rst mid-HOLD → all outputs 0 on the next edge.
- **Parameter sweep:** N=16, STABLE_CYCLES=1, mode=1, din=16'h8000 → code_out=5'd16 valid after the 1st edge. With code_ready tied high → code_valid high for exactly one cycle.
